// File: rtl/pll_dyncfg_pkg.sv
// pll_dyncfg_pkg: shared types and helpers for the EF2 PLL dynamic-reconfiguration controller.
//   state_e      - controller FSM states
//   tbl_entry_t  - one stored register write {addr, data}, sized to the widest EF2 dyncfg port
//   cw()         - counter/index width helper that never returns zero
package pll_dyncfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RST       = 2'd1,
    ST_WR        = 2'd2,
    ST_WAIT_LOCK = 2'd3
  } state_e;

  // Table entries are stored at these widths; ADDR_W/DATA_W of the controller must not exceed them.
  localparam int PLL_AW_MAX = 8;
  localparam int PLL_DW_MAX = 16;

  typedef struct packed {
    logic [PLL_AW_MAX-1:0] addr;
    logic [PLL_DW_MAX-1:0] data;
  } tbl_entry_t;

  // Bits needed to hold values 0..n-1, minimum 1.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_dyncfg_ctrl_if.sv
// pll_dyncfg_ctrl_if: SoC-side bus of the PLL reconfiguration controller.
//   req_valid/req_profile/req_ready - reconfiguration request handshake
//   tbl_we/tbl_idx/tbl_addr/tbl_data - profile-table write port
// master = SoC side, slave = controller side.
interface pll_dyncfg_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 5,
  parameter int PROF_W = 2
);
  logic              req_valid;
  logic [PROF_W-1:0] req_profile;
  logic              req_ready;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_idx;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_data;

  modport master (
    output req_valid, req_profile, tbl_we, tbl_idx, tbl_addr, tbl_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_profile, tbl_we, tbl_idx, tbl_addr, tbl_data,
    output req_ready
  );
endinterface

// File: rtl/pll_lock_qual.sv
// pll_lock_qual: extlock synchroniser plus stability / timeout qualification.
//   clk, rst_n  - clock, async active-low reset
//   extlock_i   - raw PLL lock (asynchronous)
//   en_i        - qualification window; counters held at zero while low
//   lk_s_o      - synchronised lock level
//   stable_o    - one-cycle pulse once lk_s has been high LOCK_STABLE consecutive cycles
//   timeout_o   - one-cycle pulse once the window has been open LOCK_TIMEOUT cycles
module pll_lock_qual
  import pll_dyncfg_pkg::*;
#(
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic extlock_i,
  input  logic en_i,
  output logic lk_s_o,
  output logic stable_o,
  output logic timeout_o
);
  localparam int SW = cw(LOCK_STABLE + 1);
  localparam int TW = cw(LOCK_TIMEOUT + 1);
  localparam logic [SW-1:0] S_MAX = SW'(LOCK_STABLE);
  localparam logic [TW-1:0] T_MAX = TW'(LOCK_TIMEOUT);

  logic          s1_q, lk_q;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          stable_q, stable_d, tmo_q, tmo_d;

  // Counters saturate so a late FSM reaction cannot wrap them; the pulses are
  // registered and one-shot so each threshold crossing is reported once.
  always_comb begin
    scnt_d = '0;
    tcnt_d = '0;
    if (en_i) begin
      if (lk_q) scnt_d = (scnt_q == S_MAX) ? scnt_q : scnt_q + 1'b1;
      tcnt_d = (tcnt_q == T_MAX) ? tcnt_q : tcnt_q + 1'b1;
    end
    stable_d = en_i && (scnt_q == S_MAX) && !stable_q;
    tmo_d    = en_i && (tcnt_q == T_MAX) && !tmo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      lk_q     <= 1'b0;
      scnt_q   <= '0;
      tcnt_q   <= '0;
      stable_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      s1_q     <= extlock_i;
      lk_q     <= s1_q;
      scnt_q   <= scnt_d;
      tcnt_q   <= tcnt_d;
      stable_q <= stable_d;
      tmo_q    <= tmo_d;
    end
  end

  assign lk_s_o    = lk_q;
  assign stable_o  = stable_q;
  assign timeout_o = tmo_q;
endmodule

// File: rtl/pll_dyncfg_ctrl.sv
// pll_dyncfg_ctrl: EF2 PLL dynamic-reconfiguration and lock manager.
// Stores NUM_PROFILES x WRITES_PER_PROFILE register writes; on request holds the PLL
// in reset, replays one profile on dcs/dwe/daddr/di, releases reset and qualifies lock.
//   clk, rst_n     - sole clock (also PLL dclk), async active-low reset (clears the table)
//   bus (slave)    - request handshake and table write port
//   pll_reset      - PLL reset, high during RST and WR
//   dcs/dwe/daddr/di - registered dynamic-config write port, active only in WR
//   extlock        - raw PLL lock
//   busy           - sequence in progress, through the done/err cycle
//   lock_ok        - qualified lock level
//   done/err       - one-cycle completion / lock-timeout pulses
//   relock_cnt     - saturating count of automatic re-runs (PLL_DYNCFG_LOL_MON_EN only)
// Optional feature macro: PLL_DYNCFG_LOL_MON_EN - loss of lock in IDLE re-applies the last profile.
module pll_dyncfg_ctrl
  import pll_dyncfg_pkg::*;
#(
  parameter int NUM_PROFILES       = 4,
  parameter int WRITES_PER_PROFILE = 8,
  parameter int ADDR_W             = 6,
  parameter int DATA_W             = 8,
  parameter int RST_HOLD           = 16,
  parameter int LOCK_STABLE        = 256,
  parameter int LOCK_TIMEOUT       = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  pll_dyncfg_ctrl_if.slave  bus,
  output logic              pll_reset,
  output logic              dcs,
  output logic              dwe,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] di,
  input  logic              extlock,
  output logic              busy,
  output logic              lock_ok,
  output logic              done,
  output logic              err
`ifdef PLL_DYNCFG_LOL_MON_EN
  ,
  output logic [15:0]       relock_cnt
`endif
);
  localparam int NENT   = NUM_PROFILES * WRITES_PER_PROFILE;
  localparam int IDX_W  = cw(NENT);
  localparam int PROF_W = cw(NUM_PROFILES);
  localparam int CW     = cw((RST_HOLD > WRITES_PER_PROFILE) ? RST_HOLD : WRITES_PER_PROFILE);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PROF_W-1:0] prof_q, prof_d, req_prof_c;
  logic              accept;
  tbl_entry_t        tbl_q [NENT];
  tbl_entry_t        entry;
  logic [IDX_W-1:0]  rd_idx;
  logic              lk_s, stable, timeout;

  logic              pll_reset_q, pll_reset_d, dcs_q, dcs_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              busy_q, busy_d, lock_ok_q, lock_ok_d;
  logic              done_q, done_d, err_q, err_d;
`ifdef PLL_DYNCFG_LOL_MON_EN
  logic              auto_run;
  logic [15:0]       relock_q, relock_d;
`endif

  pll_lock_qual #(.LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)) u_qual (
    .clk       (clk),
    .rst_n     (rst_n),
    .extlock_i (extlock),
    .en_i      (state_q == ST_WAIT_LOCK),
    .lk_s_o    (lk_s),
    .stable_o  (stable),
    .timeout_o (timeout)
  );

  always_comb
    req_prof_c = (int'(bus.req_profile) > NUM_PROFILES - 1) ? PROF_W'(NUM_PROFILES - 1)
                                                            : bus.req_profile;

  // Next state. cnt_q counts RST hold cycles, then the write index within WR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prof_d  = prof_q;
    accept  = 1'b0;
`ifdef PLL_DYNCFG_LOL_MON_EN
    auto_run = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          prof_d = req_prof_c;
        end
`ifdef PLL_DYNCFG_LOL_MON_EN
        else if (lock_ok_q && !lk_s) begin
          // lock lost: re-apply prof_q, which is 0 until the first request
          accept   = 1'b1;
          auto_run = 1'b1;
        end
`endif
        if (accept) begin
          state_d = ST_RST;
          cnt_d   = '0;
        end
      end
      ST_RST:
        if (cnt_q == CW'(RST_HOLD - 1)) begin
          state_d = ST_WR;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      ST_WR:
        if (cnt_q == CW'(WRITES_PER_PROFILE - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      ST_WAIT_LOCK:
        if (stable || timeout) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with state_q.
  always_comb rd_idx = (state_d == ST_WR) ? IDX_W'(int'(prof_d) * WRITES_PER_PROFILE + int'(cnt_d)) : '0;
  assign entry = tbl_q[rd_idx];

  always_comb begin
    pll_reset_d = (state_d == ST_RST) || (state_d == ST_WR);
    dcs_d       = (state_d == ST_WR);
    daddr_d     = dcs_d ? ADDR_W'(entry.addr) : '0;
    di_d        = dcs_d ? DATA_W'(entry.data) : '0;
    done_d      = (state_q == ST_WAIT_LOCK) && stable;
    err_d       = (state_q == ST_WAIT_LOCK) && timeout && !stable;  // done wins a tie
    busy_d      = (state_d != ST_IDLE) || done_d || err_d;
    lock_ok_d   = lock_ok_q;
    if (accept)                            lock_ok_d = 1'b0;
    else if (done_d)                       lock_ok_d = 1'b1;
    else if (err_d)                        lock_ok_d = 1'b0;
    else if (state_q == ST_IDLE && !lk_s)  lock_ok_d = 1'b0;
`ifdef PLL_DYNCFG_LOL_MON_EN
    relock_d = (auto_run && relock_q != 16'hFFFF) ? relock_q + 16'd1 : relock_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      prof_q      <= '0;
      pll_reset_q <= 1'b0;
      dcs_q       <= 1'b0;
      daddr_q     <= '0;
      di_q        <= '0;
      busy_q      <= 1'b0;
      lock_ok_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PLL_DYNCFG_LOL_MON_EN
      relock_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prof_q      <= prof_d;
      pll_reset_q <= pll_reset_d;
      dcs_q       <= dcs_d;
      daddr_q     <= daddr_d;
      di_q        <= di_d;
      busy_q      <= busy_d;
      lock_ok_q   <= lock_ok_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef PLL_DYNCFG_LOL_MON_EN
      relock_q    <= relock_d;
`endif
    end
  end

  // Table writes land only in IDLE; a write on the acceptance edge is seen by the
  // replay because WR reads the table no earlier than RST_HOLD cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) tbl_q[i] <= '0;
    end else if (bus.tbl_we && state_q == ST_IDLE && int'(bus.tbl_idx) < NENT) begin
      tbl_q[bus.tbl_idx] <= '{addr: PLL_AW_MAX'(bus.tbl_addr), data: PLL_DW_MAX'(bus.tbl_data)};
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign pll_reset     = pll_reset_q;
  assign dcs           = dcs_q;
  assign dwe           = dcs_q;
  assign daddr         = daddr_q;
  assign di            = di_q;
  assign busy          = busy_q;
  assign lock_ok       = lock_ok_q;
  assign done          = done_q;
  assign err           = err_q;
`ifdef PLL_DYNCFG_LOL_MON_EN
  assign relock_cnt    = relock_q;
`endif
endmodule

// File: tb/tb_pll_dyncfg_ctrl.sv
// tb_pll_dyncfg_ctrl: scoreboard bench for pll_dyncfg_ctrl. The stimulus process pushes
// the expected write beats and done/err events; a negedge monitor pops and compares them.
module tb_pll_dyncfg_ctrl;
  localparam int NP = 3, WPP = 8, AW = 6, DW = 8, RH = 16, LS = 256, LT = 1000;
  localparam int WR0        = 17;    // 1 + RST_HOLD: first write cycle after acceptance
  localparam int DONE_LAT   = 283;   // 1 + 16 + 8 + 2 + 256
  localparam int ERR_LAT    = 1027;  // 1 + 16 + 8 + 2 + 1000
  localparam int GLITCH_LAT = 486;   // extlock back high at 226: 226 + 2 sync + 256 + 2

  typedef struct { int cyc; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int cyc; bit is_err; } ev_t;

  logic clk = 1'b0, rst_n = 1'b0, extlock = 1'b0;
  logic pll_reset, dcs, dwe, busy, lock_ok, done, err;
  logic [AW-1:0] daddr;
  logic [DW-1:0] di;
`ifdef PLL_DYNCFG_LOL_MON_EN
  logic [15:0] relock_cnt;
`endif
  int cyc = 0, tests = 0, fails = 0;
  wr_t wq[$];
  ev_t eq[$];
  wr_t w;
  ev_t e;
  logic [AW-1:0] m_addr [NP*WPP];
  logic [DW-1:0] m_data [NP*WPP];

  pll_dyncfg_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(5), .PROF_W(2)) bus();

  pll_dyncfg_ctrl #(.NUM_PROFILES(NP), .WRITES_PER_PROFILE(WPP), .ADDR_W(AW), .DATA_W(DW),
                    .RST_HOLD(RH), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pll_reset(pll_reset), .dcs(dcs), .dwe(dwe),
    .daddr(daddr), .di(di), .extlock(extlock), .busy(busy), .lock_ok(lock_ok),
    .done(done), .err(err)
`ifdef PLL_DYNCFG_LOL_MON_EN
    , .relock_cnt(relock_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dcs) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: daddr=%0h di=%0h at cycle %0d", daddr, di, cyc);
        end else begin
          w = wq.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
          chk("daddr", 32'(daddr), 32'(w.a));
          chk("di", 32'(di), 32'(w.d));
          chk("dwe", 32'(dwe), 32'd1);
        end
      end
      if (done || err) begin
        if (eq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_event: done=%0b err=%0b at cycle %0d", done, err, cyc);
        end else begin
          e = eq.pop_front();
          chk("evt_err", 32'(err), 32'(e.is_err));
          chk("evt_done", 32'(done), 32'(!e.is_err));
          chk("evt_cycle", 32'(cyc), 32'(e.cyc));
          chk("lock_ok_at_evt", 32'(lock_ok), 32'(!e.is_err));
          chk("ready_at_evt", 32'(bus.req_ready), 32'd1);
        end
      end
    end
  end

  // All driver tasks start and end #1 after a rising edge.
  task automatic tbl_write(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit honor);
    bus.tbl_we = 1'b1; bus.tbl_idx = 5'(idx); bus.tbl_addr = a; bus.tbl_data = d;
    if (honor) begin m_addr[idx] = a; m_data[idx] = d; end
    @(posedge clk); #1;
    bus.tbl_we = 1'b0;
  endtask

  task automatic expect_run(input int acc, input int p, input int evt, input int lat);
    for (int n = 0; n < WPP; n++) wq.push_back('{acc + WR0 + n, m_addr[p*WPP+n], m_data[p*WPP+n]});
    if (evt != 0) eq.push_back('{acc + lat, evt == 2});
  endtask

  task automatic request(input int prof, input int evt, input int lat, input bit wr,
                         input int widx, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         output int acc);
    bus.req_valid = 1'b1; bus.req_profile = 2'(prof);
    if (wr) begin
      bus.tbl_we = 1'b1; bus.tbl_idx = 5'(widx); bus.tbl_addr = wa; bus.tbl_data = wd;
      m_addr[widx] = wa; m_data[widx] = wd;
    end
    acc = cyc;
    expect_run(acc, (prof > NP - 1) ? NP - 1 : prof, evt, lat);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.tbl_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || !bus.req_ready) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL idle_wait: busy=%0b still set after %0d cycles", busy, n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    bus.req_valid = 1'b0; bus.req_profile = '0; bus.tbl_we = 1'b0;
    bus.tbl_idx = '0; bus.tbl_addr = '0; bus.tbl_data = '0;
    for (int i = 0; i < NP*WPP; i++) begin m_addr[i] = '0; m_data[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pll_reset", 32'(pll_reset), 0); chk("rst_dcs", 32'(dcs), 0);
    chk("rst_dwe", 32'(dwe), 0);             chk("rst_daddr", 32'(daddr), 0);
    chk("rst_di", 32'(di), 0);               chk("rst_busy", 32'(busy), 0);
    chk("rst_lock_ok", 32'(lock_ok), 0);     chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);             chk("rst_req_ready", 32'(bus.req_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // profile 2: addr 0x10+n, data 0xA0+n, steady lock
    for (int n = 0; n < WPP; n++) tbl_write(16 + n, 6'(8'h10 + n), 8'(8'hA0 + n), 1'b1);
    extlock = 1'b1;
    repeat (3) @(posedge clk); #1;
    request(2, 1, DONE_LAT, 1'b0, 0, '0, '0, acc);
    @(negedge clk);
    chk("lat_pll_reset", 32'(pll_reset), 1); chk("lat_busy", 32'(busy), 1);
    chk("lat_req_ready", 32'(bus.req_ready), 0);
    wait_idle();
    chk("lock_ok_after_done", 32'(lock_ok), 1);

    // out-of-range profile clamps to NP-1; acceptance clears lock_ok
    request(3, 1, DONE_LAT, 1'b0, 0, '0, '0, acc);
    @(negedge clk);
    chk("lock_ok_clr_on_accept", 32'(lock_ok), 0);
    wait_idle();

    // one-cycle extlock glitch at stability count 200
    request(2, 1, GLITCH_LAT, 1'b0, 0, '0, '0, acc);
    repeat (224) @(posedge clk); #1 extlock = 1'b0;
    @(posedge clk); #1 extlock = 1'b1;
    wait_idle();

`ifdef PLL_DYNCFG_LOL_MON_EN
    // lock lost in IDLE: automatic re-run of profile 2, which then times out
    extlock = 1'b0;
    expect_run(cyc + 2, 2, 2, ERR_LAT);
    repeat (4) @(posedge clk); #1;
    wait_idle();
    chk("relock_cnt", 32'(relock_cnt), 1);
`else
    // lock lost in IDLE: lock_ok just drops; then a request with no lock times out
    extlock = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lock_ok_drop", 32'(lock_ok), 0);
    chk("no_auto_rerun", 32'(busy), 0);
    @(posedge clk); #1;
    request(0, 2, ERR_LAT, 1'b0, 0, '0, '0, acc);
    wait_idle();
`endif

    // table write during WR is ignored
    extlock = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int n = 0; n < WPP; n++) tbl_write(8 + n, 6'(8'h20 + n), 8'(8'h50 + n), 1'b1);
    request(1, 1, DONE_LAT, 1'b0, 0, '0, '0, acc);
    repeat (17) @(posedge clk); #1;
    tbl_write(8, 6'h3F, 8'hFF, 1'b0);
    wait_idle();
    request(1, 1, DONE_LAT, 1'b0, 0, '0, '0, acc);
    wait_idle();

    // write on the acceptance edge is used by that run
    request(1, 1, DONE_LAT, 1'b1, 9, 6'h01, 8'h77, acc);
    wait_idle();

    // reset mid-WR: outputs clear at once, table cleared
    request(2, 0, 0, 1'b0, 0, '0, '0, acc);
    repeat (19) @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst_pll_reset", 32'(pll_reset), 0); chk("midrst_dcs", 32'(dcs), 0);
    chk("midrst_busy", 32'(busy), 0);           chk("midrst_req_ready", 32'(bus.req_ready), 1);
    chk("midrst_writes_left", 32'(wq.size()), 5);
    wq.delete();
    for (int i = 0; i < NP*WPP; i++) begin m_addr[i] = '0; m_data[i] = '0; end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    request(2, 1, DONE_LAT, 1'b0, 0, '0, '0, acc);
    wait_idle();

    chk("scoreboard_drained", 32'(wq.size() + eq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pll_dyncfg_ctrl.md
# pll_dyncfg_ctrl

Parametrised dynamic-reconfiguration and lock manager for the EF2 PLL primitive. It stores several register-write profiles and, on request, holds the PLL in reset and replays one profile over the PLL's dynamic-configuration port (dcs/dwe/daddr/di). It then releases reset and qualifies extlock for stability, with a timeout. It sits beside the generated PLL wrapper and gives the SoC run-time frequency switching with a clean lock indication.

## Interface
- NUM_PROFILES, 4: number of stored profiles (≥1)
- WRITES_PER_PROFILE, 8: register writes replayed per profile (≥1)
- ADDR_W, 6: PLL dynamic-config address width
- DATA_W, 8: PLL dynamic-config data width
- RST_HOLD, 16: cycles pll_reset is held before the first write (≥1)
- LOCK_STABLE, 256: consecutive synced-lock cycles required to declare lock (≥1)
- LOCK_TIMEOUT, 65535: cycles allowed from reset release to stable lock

Ports:
- clk  in  1  sole clock; also drives PLL dclk
- rst_n  in  1  asynchronous, active-low reset
- tbl_we  in  1  profile-table write strobe
- tbl_idx  in  clog2(NUM_PROFILES*WRITES_PER_PROFILE)  table entry index (profile*WRITES_PER_PROFILE+n)
- tbl_addr / tbl_data  in  ADDR_W / DATA_W  entry contents
- req_valid  in  1  reconfiguration request
- req_profile  in  clog2(NUM_PROFILES)  profile to apply
- req_ready  out  1  high only in IDLE
- pll_reset  out  1  drives PLL reset
- dcs, dwe  out  1  dynamic-config strobes
- daddr / di  out  ADDR_W / DATA_W  dynamic-config address/data
- extlock  in  1  PLL lock, asynchronous to clk
- busy  out  1  sequence in progress
- lock_ok  out  1  qualified lock level
- done / err  out  1  single-cycle completion / timeout pulses

## Operation
- FSM states: IDLE → RST → WR → WAIT_LOCK → IDLE.
- IDLE: req_ready=1. On req_valid, latch req_profile, clear counters, go to RST.
- RST: pll_reset=1 for RST_HOLD cycles, then go to WR.
- WR: pll_reset stays 1. One entry per cycle, n=0..WRITES_PER_PROFILE-1, with dcs=dwe=1 and daddr/di taken from the table. After the last entry, go to WAIT_LOCK.
- WAIT_LOCK: pll_reset=0. extlock passes through a 2-flop synchroniser (lk_s). A stability counter counts up while lk_s=1 and clears whenever lk_s=0.
  - Counter reaches LOCK_STABLE: pulse done, set lock_ok, go to IDLE.
  - Timeout counter reaches LOCK_TIMEOUT first: pulse err, lock_ok=0, go to IDLE.
  - Both on the same cycle: done wins.
- lock_ok clears on request acceptance. In IDLE it clears on the first cycle lk_s=0.
- Table writes:
  - Honoured only in IDLE; ignored while busy.
  - A write and a request on the same edge: the write lands first, and the sequence uses the new value.
- Out-of-range req_profile is clamped to NUM_PROFILES-1.
- rst_n asserted mid-sequence: immediate return to IDLE, all outputs go to reset values, table cleared.

## Timing
- Reset values: pll_reset=0, dcs=dwe=0, daddr=0, di=0, busy=0, lock_ok=0, done=err=0, req_ready=1. The table holds all zeros.
- Strobes: dcs/dwe/daddr/di are registered; dcs/dwe are 0 outside WR.
- Latency: pll_reset rises 1 cycle after acceptance. WR lasts exactly WRITES_PER_PROFILE cycles. If extlock is steady high, done arrives at 1+RST_HOLD+WRITES_PER_PROFILE+2+LOCK_STABLE cycles after acceptance.
- busy: high from the cycle after acceptance through the done/err cycle.

## Configuration
- PLL_DYNCFG_LOL_MON_EN defined: in IDLE with lock_ok=1, a falling lk_s triggers an automatic re-run of the last applied profile.
  - Before any request, the auto re-run uses profile 0.
  - A 16-bit saturating relock_cnt output counts auto re-runs.
  - An external request on the same cycle as a loss of lock takes priority.
- Macro undefined: lock_ok simply drops, no auto re-run happens, and the relock_cnt port is absent.

## Structure
- Package pll_dyncfg_pkg:
  - state enum
  - table-entry struct {addr, data}
  - counter-width helpers
- Sub-module pll_lock_qual: 2-flop synchroniser plus stability and timeout counters. Outputs: stable and timeout pulses.

## Test plan
- Load profile 2 with addr=0x10+n, data=0xA0+n; request profile 2 with extlock high. Expect:
  - 8 write cycles with daddr 0x10..0x17 and di 0xA0..0xA7
  - done at cycle 1+16+8+2+256
  - lock_ok=1
- extlock held low after request with LOCK_TIMEOUT=1000 → err pulse 1000 cycles after reset release; lock_ok=0; back in IDLE.
- extlock glitches low at stability count 200 → counter restarts; done arrives 256 cycles after the glitch ends.
- tbl_we during WR → table unchanged; a following request replays the old data. tbl_we in the same cycle as req_valid → new data used.
- rst_n pulled low in WR → next cycle pll_reset=0, dcs=0, busy=0, and the table reads back zero.
- With PLL_DYNCFG_LOL_MON_EN, drop extlock while lock_ok=1 → sequence restarts with the last profile and relock_cnt=1.
